// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default sizing for the memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DATA_W          = 16;
    localparam int unsigned MEM_ARB_BURST   = 8;
    localparam int unsigned MEM_ARB_LATENCY = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-port signals of the memory arbiter.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_gnt;
    logic [DATA_W-1:0]     i_data;
    logic                  i_valid;
    logic                  i_done;

    logic                  d_req;
    logic                  d_wr;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_gnt;
    logic [DATA_W-1:0]     d_data;
    logic                  d_valid;
    logic                  d_done;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_enable;
    logic                  mem_wr;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_data, i_valid, i_done,
        output d_gnt, d_data, d_valid, d_done,
        output mem_addr, mem_wdata, mem_enable, mem_wr
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_data, i_valid, i_done,
        input  d_gnt, d_data, d_valid, d_done,
        input  mem_addr, mem_wdata, mem_enable, mem_wr
    );

endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational owner selection for mem_arbiter.
// MEM_ARB_RR_EN: when defined, contention alternates between the sides;
// otherwise the D side always wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  owner_e last_own,
`endif
    input  logic   i_req,
    input  logic   d_req,
    output logic   req_c,
    output owner_e own_c
);

    // Pick the owner for a request seen this cycle
    always_comb begin
        req_c = i_req | d_req;
        own_c = d_req ? OWN_D : OWN_I;
`ifdef MEM_ARB_RR_EN
        if (i_req && d_req) begin
            own_c = (last_own == OWN_D) ? OWN_I : OWN_D;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises I-fill and D-fill/write requests onto one memory port,
// with a fixed wait before the first beat. MEM_ARB_RR_EN selects round-robin
// arbitration (default build: fixed D-over-I priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned BURST      = MEM_ARB_BURST,
    parameter int unsigned LATENCY    = MEM_ARB_LATENCY
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    localparam int unsigned AW     = ADDR_WIDTH;
    localparam int unsigned BEAT_W = $clog2(BURST);
    localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [AW-1:0] RD_MASK = ~AW'(2 * BURST - 1);
    localparam logic [AW-1:0] WR_MASK = ~AW'(1);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_WAIT = ST_WAIT;
    localparam logic [1:0] S_XFER = ST_XFER;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    owner_e            own_q, own_d;
    logic              wr_q, wr_d;
    logic [AW-1:0]     base_q, base_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [AW-1:0]     req_addr;
    logic [DATA_W-1:0] rd_data_d;
    logic              rd_valid_d;
    logic              pick_req;
    owner_e            pick_own;

    logic              i_gnt_q, i_gnt_d, i_valid_q, i_valid_d, i_done_q, i_done_d;
    logic              d_gnt_q, d_gnt_d, d_valid_q, d_valid_d, d_done_q, d_done_d;
    logic [DATA_W-1:0] i_data_q, i_data_d, d_data_q, d_data_d;
    logic              mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

`ifdef MEM_ARB_RR_EN
    owner_e last_q;

    // Remember which side was granted last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= OWN_I;
        end else if (state_q == S_IDLE && pick_req) begin
            last_q <= pick_own;
        end
    end
`endif

    mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
        .last_own (last_q),
`endif
        .i_req    (bus.i_req),
        .d_req    (bus.d_req),
        .req_c    (pick_req),
        .own_c    (pick_own)
    );

    // Next-state, counters, latched request and next output values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        own_d      = own_q;
        wr_d       = wr_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        req_addr   = bus.i_addr;
        rd_data_d  = '0;
        rd_valid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (pick_req) begin
                    state_d = S_WAIT;
                    own_d   = pick_own;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    if (pick_own == OWN_D) begin
                        wr_d     = bus.d_wr;
                        req_addr = bus.d_addr;
                        wdata_d  = bus.d_wr ? bus.d_wdata : '0;
                    end else begin
                        wr_d    = 1'b0;
                        wdata_d = '0;
                    end
                    base_d = wr_d ? (req_addr & WR_MASK) : (req_addr & RD_MASK);
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_XFER;
                    beat_d  = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_XFER: begin
                if (!wr_q) begin
                    rd_data_d  = bus.mem_rdata;
                    rd_valid_d = 1'b1;
                end
                if (wr_q || beat_q == BEAT_W'(BURST - 1)) begin
                    state_d = S_DONE;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_en_d    = (state_d == S_XFER);
        mem_wr_d    = mem_en_d & wr_d;
        mem_addr_d  = mem_en_d ? base_d + (AW'(beat_d) << 1) : '0;
        mem_wdata_d = mem_en_d ? wdata_d : '0;
        i_gnt_d     = (state_d != S_IDLE) && (own_d == OWN_I);
        d_gnt_d     = (state_d != S_IDLE) && (own_d == OWN_D);
        i_done_d    = (state_d == S_DONE) && (own_d == OWN_I);
        d_done_d    = (state_d == S_DONE) && (own_d == OWN_D);
        i_valid_d   = rd_valid_d && (own_q == OWN_I);
        d_valid_d   = rd_valid_d && (own_q == OWN_D);
        i_data_d    = i_valid_d ? rd_data_d : '0;
        d_data_d    = d_valid_d ? rd_data_d : '0;
    end

    // State, transaction context and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            beat_q      <= '0;
            own_q       <= OWN_I;
            wr_q        <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            i_gnt_q     <= 1'b0;
            i_valid_q   <= 1'b0;
            i_done_q    <= 1'b0;
            i_data_q    <= '0;
            d_gnt_q     <= 1'b0;
            d_valid_q   <= 1'b0;
            d_done_q    <= 1'b0;
            d_data_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            beat_q      <= beat_d;
            own_q       <= own_d;
            wr_q        <= wr_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            i_gnt_q     <= i_gnt_d;
            i_valid_q   <= i_valid_d;
            i_done_q    <= i_done_d;
            i_data_q    <= i_data_d;
            d_gnt_q     <= d_gnt_d;
            d_valid_q   <= d_valid_d;
            d_done_q    <= d_done_d;
            d_data_q    <= d_data_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.i_gnt      = i_gnt_q;
    assign bus.i_data     = i_data_q;
    assign bus.i_valid    = i_valid_q;
    assign bus.i_done     = i_done_q;
    assign bus.d_gnt      = d_gnt_q;
    assign bus.d_data     = d_data_q;
    assign bus.d_valid    = d_valid_q;
    assign bus.d_done     = d_done_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_enable = mem_en_q;
    assign bus.mem_wr     = mem_wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random requests against a transaction-level
// timing model of mem_arbiter (honours MEM_ARB_RR_EN when defined).
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 16;
    localparam int N  = 8;
    localparam int L  = 4;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    mem_arbiter #(.ADDR_WIDTH(AW), .BURST(N), .LATENCY(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory device: word at byte address a holds a unless written (stored as xor delta)
    bit [15:0] mem_delta [0:32767];
    assign bus.mem_rdata = mem_delta[bus.mem_addr[15:1]] ^ {bus.mem_addr[15:1], 1'b0};
    always @(posedge clk) begin
        if (bus.mem_enable && bus.mem_wr)
            mem_delta[bus.mem_addr[15:1]] <= bus.mem_wdata ^ {bus.mem_addr[15:1], 1'b0};
    end

    // Reference model state
    logic [15:0] ref_mem [0:32767];
    int          cyc;
    bit          tx_v, tx_d, tx_wr, last_d;
    int          tx_t0, idle_from;
    logic [15:0] tx_base, tx_wdata;

    int n_chk, n_err;

    // Observations used by the directed checks
    int          i_gnt_at, d_gnt_at, i_done_at, d_done_at, i_vcnt, d_vcnt;
    logic [15:0] i_first, d_first;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int tx_len();
        return tx_wr ? L + 2 : L + N + 1;
    endfunction

    task automatic clr_obs();
        i_gnt_at = -1; d_gnt_at = -1; i_done_at = -1; d_done_at = -1;
        i_vcnt = 0; d_vcnt = 0; i_first = '0; d_first = '0;
    endtask

    // Model update at the end of cycle cyc, using the inputs of that cycle
    task automatic model_edge();
        logic [15:0] a;
        bit          pd;
        if (!rst_n) begin
            tx_v      = 1'b0;
            last_d    = 1'b0;
            idle_from = cyc + 1;
        end else begin
            if (tx_v && tx_wr && (cyc - tx_t0) == L + 1)
                ref_mem[tx_base[15:1]] = tx_wdata;
            if (cyc >= idle_from && (bus.i_req || bus.d_req)) begin
                pd = bus.d_req;
`ifdef MEM_ARB_RR_EN
                if (bus.d_req && bus.i_req) pd = !last_d;
                last_d = pd;
`endif
                a         = pd ? bus.d_addr : bus.i_addr;
                tx_v      = 1'b1;
                tx_t0     = cyc;
                tx_d      = pd;
                tx_wr     = pd && bus.d_wr;
                tx_base   = tx_wr ? (a & 16'hFFFE) : (a & ~16'(2 * N - 1));
                tx_wdata  = tx_wr ? bus.d_wdata : 16'h0000;
                idle_from = cyc + tx_len() + 1;
            end
        end
        cyc++;
    endtask

    // Compare every DUT output with the model for the current cycle
    task automatic check_outputs();
        logic        e_ig, e_dg, e_iv, e_dv, e_idn, e_ddn, e_en, e_wr;
        logic [15:0] e_id, e_dd, e_ma, e_md, w;
        int          rel, nb;
        e_ig = 0; e_dg = 0; e_iv = 0; e_dv = 0; e_idn = 0; e_ddn = 0; e_en = 0; e_wr = 0;
        e_id = '0; e_dd = '0; e_ma = '0; e_md = '0;
        if (rst_n && tx_v) begin
            rel = cyc - tx_t0;
            nb  = tx_wr ? 1 : N;
            if (rel >= 1 && rel <= tx_len()) begin
                if (tx_d) e_dg = 1; else e_ig = 1;
            end
            if (rel >= L + 1 && rel <= L + nb) begin
                e_en = 1;
                e_wr = tx_wr;
                e_ma = tx_base + 16'(2 * (rel - L - 1));
                e_md = tx_wdata;
            end
            if (!tx_wr && rel >= L + 2 && rel <= L + N + 1) begin
                w = tx_base + 16'(2 * (rel - L - 2));
                if (tx_d) begin e_dv = 1; e_dd = ref_mem[w[15:1]]; end
                else begin e_iv = 1; e_id = ref_mem[w[15:1]]; end
            end
            if (rel == tx_len()) begin
                if (tx_d) e_ddn = 1; else e_idn = 1;
            end
        end
        if (bus.i_gnt && i_gnt_at < 0) i_gnt_at = cyc;
        if (bus.d_gnt && d_gnt_at < 0) d_gnt_at = cyc;
        if (bus.i_done) i_done_at = cyc;
        if (bus.d_done) d_done_at = cyc;
        if (bus.i_valid) begin if (i_vcnt == 0) i_first = bus.i_data; i_vcnt++; end
        if (bus.d_valid) begin if (d_vcnt == 0) d_first = bus.d_data; d_vcnt++; end
        chk("i_gnt", 32'(bus.i_gnt), 32'(e_ig));
        chk("d_gnt", 32'(bus.d_gnt), 32'(e_dg));
        chk("i_valid", 32'(bus.i_valid), 32'(e_iv));
        chk("d_valid", 32'(bus.d_valid), 32'(e_dv));
        chk("i_data", 32'(bus.i_data), 32'(e_id));
        chk("d_data", 32'(bus.d_data), 32'(e_dd));
        chk("i_done", 32'(bus.i_done), 32'(e_idn));
        chk("d_done", 32'(bus.d_done), 32'(e_ddn));
        chk("mem_enable", 32'(bus.mem_enable), 32'(e_en));
        chk("mem_wr", 32'(bus.mem_wr), 32'(e_wr));
        chk("mem_addr", 32'(bus.mem_addr), 32'(e_ma));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_md));
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_gnt"}, 32'({bus.i_gnt, bus.d_gnt}), 32'(0));
        chk({tag, "_valid"}, 32'({bus.i_valid, bus.d_valid}), 32'(0));
        chk({tag, "_done"}, 32'({bus.i_done, bus.d_done}), 32'(0));
        chk({tag, "_data"}, {bus.i_data, bus.d_data}, 32'(0));
        chk({tag, "_mem"}, 32'({bus.mem_enable, bus.mem_wr}), 32'(0));
        chk({tag, "_maddr"}, {bus.mem_addr, bus.mem_wdata}, 32'(0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200 && cyc < idle_from; k++) tick();
        chk("idle_timeout", 32'(cyc >= idle_from), 32'(1));
    endtask

    // One requester transaction: hold req for `hold` cycles, then run to idle
    task automatic txn(input bit sd, input bit wr, input logic [15:0] a,
                       input logic [15:0] wd, input int hold, output int s);
        clr_obs();
        s = cyc;
        if (sd) begin
            bus.d_req = 1'b1; bus.d_wr = wr; bus.d_addr = a; bus.d_wdata = wd;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = a;
        end
        repeat (hold) tick();
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        wait_idle();
    endtask

    // Both sides request a fill in the same cycle
    task automatic contend(input bit exp_d_first);
        int s;
        clr_obs();
        s = cyc;
        bus.i_req = 1'b1; bus.i_addr = 16'h0300;
        bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0200;
        repeat (13) tick();
        if (exp_d_first) bus.d_req = 1'b0; else bus.i_req = 1'b0;
        repeat (14) tick();
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        wait_idle();
        chk("c_first_owner_d", 32'(d_gnt_at == s + 1), 32'(exp_d_first));
        chk("c_first_done", 32'((exp_d_first ? d_done_at : i_done_at) - s), 32'(13));
        chk("c_second_gnt", 32'((exp_d_first ? i_gnt_at : d_gnt_at) - s), 32'(15));
        chk("c_second_done", 32'((exp_d_first ? i_done_at : d_done_at) - s), 32'(27));
    endtask

    initial begin
        int s;
        n_chk = 0; n_err = 0; cyc = 0;
        tx_v = 0; last_d = 0; idle_from = 0;
        for (int k = 0; k < 32768; k++) ref_mem[k] = 16'(2 * k);
        clr_obs();

        rst_n = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 16'h0013;
        bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h0100; bus.d_wdata = 16'h0000;
        #1;
        zero_check("rst");
        repeat (3) tick();
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        rst_n = 1'b1;

        txn(1'b0, 1'b0, 16'h0013, 16'h0000, 13, s);
        chk("ifill_gnt_at", 32'(i_gnt_at - s), 32'(1));
        chk("ifill_done_at", 32'(i_done_at - s), 32'(13));
        chk("ifill_vcnt", 32'(i_vcnt), 32'(8));
        chk("ifill_first", 32'(i_first), 32'h0010);

        txn(1'b1, 1'b1, 16'h0100, 16'hBEEF, 6, s);
        chk("dwr_done_at", 32'(d_done_at - s), 32'(6));
        chk("dwr_vcnt", 32'(d_vcnt), 32'(0));

        txn(1'b1, 1'b0, 16'h0100, 16'h0000, 13, s);
        chk("dfill_first", 32'(d_first), 32'hBEEF);
        chk("dfill_done_at", 32'(d_done_at - s), 32'(13));

        txn(1'b0, 1'b0, 16'h0022, 16'h0000, 3, s);
        chk("idrop_done_at", 32'(i_done_at - s), 32'(13));
        chk("idrop_vcnt", 32'(i_vcnt), 32'(8));
        chk("idrop_first", 32'(i_first), 32'h0020);

        // Contention from a fresh reset, then again after a D-only transaction
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        contend(1'b1);
        txn(1'b1, 1'b0, 16'h0400, 16'h0000, 13, s);
`ifdef MEM_ARB_RR_EN
        contend(1'b0);
`else
        contend(1'b1);
`endif

        // Reset in the middle of an I fill
        clr_obs();
        s = cyc;
        bus.i_req = 1'b1; bus.i_addr = 16'h0040;
        repeat (3) tick();
        bus.i_req = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        zero_check("rst_mid");
        clr_obs();
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("rst_mid_no_done", 32'(i_done_at), 32'(-1));
        txn(1'b1, 1'b0, 16'h0080, 16'h0000, 13, s);
        chk("post_rst_done_at", 32'(d_done_at - s), 32'(13));
        chk("post_rst_first", 32'(d_first), 32'h0080);

        // Random traffic with occasional resets
        for (int k = 0; k < 1500; k++) begin
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            bus.i_req   = ($urandom_range(0, 2) == 0);
            bus.d_req   = ($urandom_range(0, 2) == 0);
            bus.d_wr    = ($urandom_range(0, 1) == 1);
            bus.i_addr  = 16'($urandom);
            bus.d_addr  = 16'($urandom);
            bus.d_wdata = 16'($urandom);
            tick();
        end
        rst_n = 1'b1;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        wait_idle();
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
